// File: rtl/uart_rx_fifo.sv
// UART receiver with build-time framing and run-time baud divisor.
// Frames are deframed from rx_i and stored as {ferr, perr, data} in a
// show-ahead FIFO whose head is always presented on the outputs.
module uart_rx_fifo #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 2,
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_W       = 16
) (
  input  logic                            clk_i,
  input  logic                            resetn_i,
  input  logic                            rx_i,
  input  logic                            en_i,
  input  logic [DIV_W-1:0]                baud_div_i,
  input  logic                            rd_i,
  input  logic                            clr_i,
  output logic [DATA_BITS-1:0]            data_o,
  output logic                            perr_o,
  output logic                            ferr_o,
  output logic                            valid_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o,
  output logic                            overrun_o,
  output logic                            busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic             ODD       = (PARITY_MODE == 2);
  localparam logic [BW-1:0]    LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [CW-1:0]    FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] MIN_DIV   = DIV_W'(4);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HI
  } state_t;

  typedef struct packed {
    logic                 ferr;
    logic                 perr;
    logic [DATA_BITS-1:0] data;
  } entry_t;

  // Line synchroniser and edge history
  logic rx_meta, rxs, rx_prev;

  // Deframer state
  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_q, cnt_q, div_in;
  logic [BW-1:0]        bit_idx_q;
  logic                 stop_idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 perr_q, ferr_q;
  logic                 push_q, push_d;
  logic                 tick, start_det;

  // FIFO storage
  entry_t         mem [FIFO_DEPTH];
  entry_t         head, entry_in;
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           overrun_q;
  logic           empty, full, do_pop, do_push, drop;

  assign div_in    = (baud_div_i < MIN_DIV) ? MIN_DIV : baud_div_i;
  assign tick      = (cnt_q == '0);
  assign start_det = rx_prev & ~rxs & en_i;

  // Two-flop synchroniser plus one history flop for falling-edge detection
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rxs     <= rx_meta;
      rx_prev <= rxs;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= IDLE;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      push_q  <= push_d;
    end
  end

  // Next-state logic; the entry push is registered so it lands one edge after the last stop sample
  // NOTE: every output of this block gets a default first, otherwise latches are inferred.
  always_comb begin
    state_d = state_q;
    push_d  = 1'b0;
    case (state_q)
      IDLE:    if (start_det) state_d = START;
      START:   if (tick) state_d = rxs ? IDLE : DATA;
      DATA:    if (tick && bit_idx_q == LAST_BIT) state_d = (PARITY_MODE != 0) ? PARITY : STOP;
      PARITY:  if (tick) state_d = STOP;
      STOP: begin
        if (tick && stop_idx_q == LAST_STOP) begin
          push_d  = 1'b1;
          state_d = (ferr_q | ~rxs) ? WAIT_HI : IDLE;
        end
      end
      WAIT_HI: if (rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (!en_i) begin
      state_d = IDLE;
      push_d  = 1'b0;
    end
  end

  // Bit-timing counter and frame datapath
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      div_q      <= MIN_DIV;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_det) begin
            div_q <= div_in;
            cnt_q <= div_in >> 1;
          end
        end
        WAIT_HI: ;
        default: cnt_q <= tick ? (div_q - DIV_W'(1)) : (cnt_q - DIV_W'(1));
      endcase
      if (tick) begin
        case (state_q)
          START: bit_idx_q <= '0;
          DATA: begin
            shreg_q    <= {rxs, shreg_q[DATA_BITS-1:1]};
            bit_idx_q  <= bit_idx_q + BW'(1);
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            stop_idx_q <= 1'b0;
          end
          PARITY: perr_q <= (^shreg_q) ^ rxs ^ ODD;
          STOP: begin
            if (!rxs) ferr_q <= 1'b1;
            stop_idx_q <= stop_idx_q + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign entry_in = {ferr_q, perr_q, shreg_q};
  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign do_pop   = rd_i & ~empty;
  assign do_push  = push_q & (~full | do_pop);
  assign drop     = push_q & full & ~do_pop;

  // FIFO pointers, occupancy and sticky overrun; clear wins over push/pop
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else if (clr_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
      if (drop) overrun_q <= 1'b1;
    end
  end

  // FIFO storage write
  // NOTE: the array has no reset; outputs are masked while empty so stale contents never show.
  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem[wr_ptr_q] <= entry_in;
  end

  assign head      = mem[rd_ptr_q];
  assign data_o    = empty ? '0 : head.data;
  assign perr_o    = empty ? 1'b0 : head.perr;
  assign ferr_o    = empty ? 1'b0 : head.ferr;
  assign valid_o   = ~empty;
  assign count_o   = count_q;
  assign overrun_o = overrun_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (default parameters: 8E2, depth 16).
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk_i = 1'b0;
  logic          resetn_i, rx_i, en_i, rd_i, clr_i;
  logic [15:0]   baud_div_i;
  logic [7:0]    data_o;
  logic          perr_o, ferr_o, valid_o, overrun_o, busy_o;
  logic [CW-1:0] count_o;

  int checks = 0;
  int errors = 0;

  uart_rx_fifo dut (
    .clk_i      (clk_i),
    .resetn_i   (resetn_i),
    .rx_i       (rx_i),
    .en_i       (en_i),
    .baud_div_i (baud_div_i),
    .rd_i       (rd_i),
    .clr_i      (clr_i),
    .data_o     (data_o),
    .perr_o     (perr_o),
    .ferr_o     (ferr_o),
    .valid_o    (valid_o),
    .count_o    (count_o),
    .overrun_o  (overrun_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: FIFO contents as a queue of received frames
  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [7:0] data;
  } ent_t;

  ent_t mq[$];
  bit   m_ovr;

  typedef struct {
    logic [7:0] data;
    bit         flip;
    bit         s1;
    bit         s2;
    logic [7:0] exp_data;
    bit         exp_perr;
    bit         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Serial frame: start, 8 data LSB first, even parity (optionally inverted), two stop bits
  task automatic send_frame(input logic [7:0] d, input bit flip, input bit s1, input bit s2,
                            input int bt, input logic end_level);
    logic [11:0] bits;
    bits = {s2, s1, (^d) ^ flip, d, 1'b0};
    for (int i = 0; i < 12; i++) begin
      rx_i = bits[i];
      repeat (bt) @(negedge clk_i);
    end
    rx_i = end_level;
  endtask

  task automatic rd_pulse();
    rd_i = 1'b1;
    @(negedge clk_i);
    rd_i = 1'b0;
  endtask

  task automatic model_push(input logic [7:0] d, input bit flip, input bit s1, input bit s2);
    ent_t e;
    e.data = d;
    e.perr = flip;
    e.ferr = !(s1 && s2);
    if (mq.size() < DEPTH) mq.push_back(e);
    else m_ovr = 1'b1;
  endtask

  task automatic pop_head();
    rd_pulse();
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic do_clear();
    clr_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
    mq.delete();
    m_ovr = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "/valid"}, valid_o, mq.size() != 0);
    check({tag, "/count"}, count_o, mq.size());
    check({tag, "/overrun"}, overrun_o, m_ovr);
    if (mq.size() != 0) begin
      check({tag, "/data"}, data_o, mq[0].data);
      check({tag, "/perr"}, perr_o, mq[0].perr);
      check({tag, "/ferr"}, ferr_o, mq[0].ferr);
    end else begin
      check({tag, "/data0"}, data_o, 0);
      check({tag, "/perr0"}, {ferr_o, perr_o}, 0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/valid"}, valid_o, 0);
    check({tag, "/count"}, count_o, 0);
    check({tag, "/overrun"}, overrun_o, 0);
    check({tag, "/busy"}, busy_o, 0);
    check({tag, "/head"}, {ferr_o, perr_o, data_o}, 0);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen_hi, seen_lo;
    int bt;
    logic [7:0] d;
    bit flip, s1, s2;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, 1'b0, 1'b0};
    vecs[1] = '{8'h0D, 1'b1, 1'b1, 1'b1, 8'h0D, 1'b1, 1'b0};
    vecs[2] = '{8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1};
    vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[5] = '{8'h80, 1'b1, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1};

    resetn_i   = 1'b0;
    rx_i       = 1'b1;
    en_i       = 1'b1;
    rd_i       = 1'b0;
    clr_i      = 1'b0;
    baud_div_i = 16'd87;
    m_ovr      = 1'b0;
    idle(3);
    check_reset_outputs("reset");
    resetn_i = 1'b1;
    idle(5);

    // Table-driven frames at div=87, each read back and popped
    foreach (vecs[i]) begin
      send_frame(vecs[i].data, vecs[i].flip, vecs[i].s1, vecs[i].s2, 87, 1'b1);
      idle(95);
      check($sformatf("vec%0d/valid", i), valid_o, 1);
      check($sformatf("vec%0d/count", i), count_o, 1);
      check($sformatf("vec%0d/data", i), data_o, vecs[i].exp_data);
      check($sformatf("vec%0d/perr", i), perr_o, vecs[i].exp_perr);
      check($sformatf("vec%0d/ferr", i), ferr_o, vecs[i].exp_ferr);
      rd_pulse();
      check($sformatf("vec%0d/popped", i), valid_o, 0);
    end

    // Stuck-low line after a framing error: exactly one entry until a fresh start
    send_frame(8'h7F, 1'b0, 1'b1, 1'b0, 87, 1'b0);
    idle(30 * 87);
    check("brk/count", count_o, 1);
    check("brk/head", {ferr_o, perr_o, data_o}, {1'b1, 1'b0, 8'h7F});
    check("brk/busy_low", busy_o, 1);
    rx_i = 1'b1;
    idle(10);
    check("brk/busy_released", busy_o, 0);
    check("brk/count_released", count_o, 1);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 87, 1'b1);
    idle(95);
    check("brk/count2", count_o, 2);
    rd_pulse();
    check("brk/next", {ferr_o, perr_o, data_o}, {1'b0, 1'b0, 8'h3C});
    rd_pulse();
    check("brk/empty", valid_o, 0);

    // Glitch shorter than half a bit is a false start
    rx_i = 1'b0;
    idle(20);
    rx_i = 1'b1;
    check("glitch/busy", busy_o, 1);
    idle(200);
    check("glitch/idle", busy_o, 0);
    check("glitch/count", count_o, 0);

    // Receiver disabled mid-frame: partial frame discarded
    fork
      send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 87, 1'b1);
      begin
        idle(87 * 4);
        en_i = 1'b0;
        @(negedge clk_i);
        check("en/busy_drop", busy_o, 0);
      end
    join
    idle(10);
    check("en/count", count_o, 0);
    en_i = 1'b1;
    idle(5);

    // Overrun: 17 frames into 16 entries
    for (int i = 0; i < 17; i++) begin
      send_frame(8'(i), 1'b0, 1'b1, 1'b1, 87, 1'b1);
      idle(95);
      model_push(8'(i), 1'b0, 1'b1, 1'b1);
    end
    check_model("ovr/full");
    for (int i = 0; i < DEPTH; i++) begin
      check_model($sformatf("ovr/pop%0d", i));
      pop_head();
    end
    check_model("ovr/drained");
    do_clear();
    check_model("ovr/cleared");

    // Full FIFO with a pop on the exact push edge
    baud_div_i = 16'd24;
    for (int i = 0; i < DEPTH; i++) begin
      send_frame(8'(8'h80 + i), 1'b0, 1'b1, 1'b1, 24, 1'b1);
      idle(32);
      model_push(8'(8'h80 + i), 1'b0, 1'b1, 1'b1);
    end
    check_model("pp/full");
    seen_hi = 1'b0;
    seen_lo = 1'b0;
    fork
      send_frame(8'h55, 1'b0, 1'b1, 1'b1, 24, 1'b1);
      begin
        for (int k = 0; k < 400 && !seen_hi; k++) begin
          @(negedge clk_i);
          if (busy_o) seen_hi = 1'b1;
        end
        for (int k = 0; k < 24 * 14 && seen_hi && !seen_lo; k++) begin
          @(negedge clk_i);
          if (!busy_o) seen_lo = 1'b1;
        end
        if (seen_lo) begin
          rd_i = 1'b1;
          @(negedge clk_i);
          rd_i = 1'b0;
        end
      end
    join
    check("pp/frame_end_seen", seen_lo, 1);
    if (seen_lo) begin
      void'(mq.pop_front());
      model_push(8'h55, 1'b0, 1'b1, 1'b1);
    end
    idle(32);
    check_model("pp/after");
    for (int i = 0; i < DEPTH; i++) begin
      check_model($sformatf("pp/pop%0d", i));
      pop_head();
    end
    check_model("pp/drained");

    // Randomised frames, divisors (including below the minimum of 4), pops and clears
    for (int it = 0; it < 30; it++) begin
      baud_div_i = 16'($urandom_range(0, 24));
      bt   = (baud_div_i < 4) ? 4 : int'(baud_div_i);
      d    = 8'($urandom_range(0, 255));
      flip = ($urandom_range(0, 3) == 0);
      s1   = ($urandom_range(0, 7) != 0);
      s2   = ($urandom_range(0, 7) != 0);
      send_frame(d, flip, s1, s2, bt, 1'b1);
      idle(bt + 8);
      model_push(d, flip, s1, s2);
      check_model($sformatf("rnd%0d", it));
      case ($urandom_range(0, 5))
        0, 1: pop_head();
        5:    do_clear();
        default: ;
      endcase
      check_model($sformatf("rnd%0d/post", it));
    end

    // Asynchronous reset in the middle of a frame's data bits
    baud_div_i = 16'd24;
    send_frame(8'h11, 1'b0, 1'b1, 1'b1, 24, 1'b1);
    idle(32);
    fork
      send_frame(8'hC3, 1'b0, 1'b1, 1'b1, 24, 1'b1);
      begin
        idle(24 * 4);
        #2 resetn_i = 1'b0;
        #1 check_reset_outputs("arst/immediate");
      end
    join
    mq.delete();
    m_ovr = 1'b0;
    idle(5);
    check_reset_outputs("arst/held");
    resetn_i = 1'b1;
    idle(50);
    check_reset_outputs("arst/released");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
